b1_bist_ctrl: RTL and testbench
===============================

Name: b1_bist_ctrl

Overview:
- Built-in self-test controller that sits directly around the mapped b1_comb core.
- Upstream, it drives the core inputs a/b/d from an LFSR pattern generator.
- Downstream, it compacts the core outputs e/f/g into a MISR signature.
- After a run it compares the signature to a golden value, so the mapped netlist can be checked for equivalence on silicon or FPGA with a single pass/fail bit.

Parameters:
- NUM_PATTERNS, 64, number of RUN cycles (patterns applied); legal range 1..65535.
- LFSR_SEED, 8'hA5, initial LFSR state; the value 0 is replaced by 8'h01.
- GOLDEN_SIG, 16'h0000, expected final MISR value; set per mapping flow.

Ports:
- clk_pad, in, 1, clock.
- rst_pad, in, 1, asynchronous active-high reset.
- start_pad, in, 1, start request; sampled only in IDLE or DONE.
- a_pad, out, 1, core stimulus bit.
- b_pad, out, 1, core stimulus bit.
- d_pad, out, 1, core stimulus bit.
- e_pad, in, 1, core response bit.
- f_pad, in, 1, core response bit.
- g_pad, in, 1, core response bit.
- busy_pad, out, 1, high in SEED and RUN.
- done_pad, out, 1, high in DONE.
- pass_pad, out, 1, done_pad && (sig_pad == GOLDEN_SIG).
- sig_pad, out, 16, current MISR value.
- count_pad, out, CW = $clog2(NUM_PATTERNS+1), patterns applied so far.

Behaviour:
- Reset: async on rst_pad high, effective mid-run with no completion.
  - State = IDLE; LFSR = 0; MISR = 0; count = 0.
  - All outputs 0.
- FSM transitions:
  - IDLE: start_pad → SEED.
  - SEED (1 cycle): LFSR ← LFSR_SEED (0 forced to 1); MISR ← 0; count ← 0; → RUN.
  - RUN: each cycle, absorb the response, advance the LFSR and increment count. When count reaches NUM_PATTERNS-1 in this cycle, → DONE.
  - DONE: hold sig and count; start_pad → SEED (rerun); otherwise stay.
- start_pad in SEED or RUN is ignored.
- Stimulus: {d_pad, b_pad, a_pad} = (state == RUN) ? LFSR[2:0] : 3'b000.
  - The core is combinational, so the response is valid in the same cycle as the stimulus.
- LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1.
  - next = {q[6:0], q[7]^q[5]^q[4]^q[3]}.
  - Never all-zero while running.
- MISR: 16-bit, polynomial 0x1021.
  - next = ({m[14:0],1'b0} ^ (m[15] ? 16'h1021 : 16'h0)) ^ {13'b0, g_pad, f_pad, e_pad}.
  - Updates only in RUN.
- Latency:
  - start (cycle 0) → busy_pad at cycle 1 (SEED).
  - First pattern at cycle 2.
  - done_pad at cycle 2+NUM_PATTERNS.
- Count: count_pad equals NUM_PATTERNS in DONE.
  - NUM_PATTERNS=1: exactly one RUN cycle, then DONE.
- pass_pad is combinational from the DONE state and MISR; it is 0 outside DONE.
- Responses (e/f/g) are ignored outside RUN; X on them outside RUN must not corrupt the MISR.

Optional Feature:
- Macro: B1_BIST_ABORT_EN.
- Defined:
  - Adds input abort_pad (1 bit).
  - abort_pad high in SEED or RUN → IDLE on the next edge.
  - Clears MISR and count; done_pad and pass_pad stay 0.
  - abort_pad has priority over RUN→DONE in the same cycle.
  - In IDLE or DONE, abort_pad is ignored.
- Undefined: no abort_pad port; a run always completes unless reset.

Decomposition:
- Package b1_bist_pkg contains:
  - state enum {IDLE, SEED, RUN, DONE};
  - LFSR_W=8, MISR_W=16;
  - MISR_POLY=16'h1021;
  - LFSR tap mask 8'hB8;
  - function lfsr_next().
- One natural sub-module, b1_misr: 16-bit signature register with a clear/enable/data[2:0] interface.
- The FSM, LFSR and counter stay in the top.

Test Plan:
- Reset then idle: assert rst_pad mid-RUN → state IDLE, all outputs 0 that cycle (async); sig_pad=0, count_pad=0.
- First patterns, with the bench CUT model attached:
  - Start at cycle 0 → cycle 2 drives a=1, b=0, d=1; CUT returns e=1, f=0, g=0; MISR becomes 16'h0001.
  - Cycle 3 drives a=0, b=1, d=0 (LFSR=8'h4A); CUT returns e=1, f=0, g=1; MISR becomes 16'h0007.
- Full run, NUM_PATTERNS=64: done_pad rises at cycle 66, count_pad=64. With GOLDEN_SIG set to the model signature, pass_pad=1; with one CUT output forced inverted, pass_pad=0.
- Boundaries:
  - NUM_PATTERNS=1: exactly one pattern, done at cycle 3.
  - LFSR_SEED=0: first pattern a=1, b=0, d=0.
  - start_pad held high through RUN: no restart.
  - start_pad in DONE: rerun that reproduces an identical signature.
- B1_BIST_ABORT_EN: abort_pad at cycle 10 → IDLE at cycle 11, done_pad never rises, sig_pad=0. A subsequent start gives a normal run.

Source files
------------

// File: rtl/b1_bist_pkg.sv
// b1_bist_pkg: shared types, widths and next-state helpers for the b1 BIST controller.
package b1_bist_pkg;

    localparam int unsigned LFSR_W = 8;
    localparam int unsigned MISR_W = 16;

    // Feedback taps of x^8+x^6+x^5+x^4+1 in Fibonacci form: bits 7,5,4,3
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEED = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } bist_state_e;

    // One LFSR step: shift left, feedback parity of the tapped bits into bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        logic w_fb;
        w_fb = ^(q & LFSR_TAPS);
        return {q[LFSR_W-2:0], w_fb};
    endfunction

    // One MISR step: CRC-style shift with polynomial fold, then XOR in the three response bits
    function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] m,
                                                    input logic [2:0]        d);
        logic [MISR_W-1:0] w_shift;
        w_shift = {m[MISR_W-2:0], 1'b0} ^ (m[MISR_W-1] ? MISR_POLY : 16'h0000);
        return w_shift ^ {13'b0_0000_0000_0000, d};
    endfunction

endpackage

// File: rtl/b1_misr.sv
// b1_misr: 16-bit multiple-input signature register compacting the three core responses.
// Clear has priority over absorb; when neither is active the signature holds, so
// whatever the core outputs outside a run never reaches the register.
module b1_misr
    import b1_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [2:0]        i_data,
    output logic [MISR_W-1:0] o_sig
);

    logic [MISR_W-1:0] r_sig;

    // Signature register: clear, absorb one response word, or hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= '0;
        end else if (i_clr) begin
            r_sig <= '0;
        end else if (i_en) begin
            r_sig <= misr_next(r_sig, i_data);
        end else begin
            r_sig <= r_sig;
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/b1_bist_ctrl.sv
// b1_bist_ctrl: BIST wrapper around the mapped b1_comb core. An LFSR drives a/b/d,
// a MISR compacts e/f/g, and the final signature is compared against GOLDEN_SIG.
// Optional feature macro: B1_BIST_ABORT_EN adds abort_pad, which cancels a
// seeding or running test and returns to IDLE with a cleared signature.
module b1_bist_ctrl
    import b1_bist_pkg::*;
#(
    parameter int unsigned        NUM_PATTERNS = 64,
    parameter logic [LFSR_W-1:0]  LFSR_SEED    = 8'hA5,
    parameter logic [MISR_W-1:0]  GOLDEN_SIG   = 16'h0000,
    localparam int unsigned       CW           = $clog2(NUM_PATTERNS + 1)
) (
    input  logic              clk_pad,
    input  logic              rst_pad,
    input  logic              start_pad,
`ifdef B1_BIST_ABORT_EN
    input  logic              abort_pad,
`endif
    output logic              a_pad,
    output logic              b_pad,
    output logic              d_pad,
    input  logic              e_pad,
    input  logic              f_pad,
    input  logic              g_pad,
    output logic              busy_pad,
    output logic              done_pad,
    output logic              pass_pad,
    output logic [MISR_W-1:0] sig_pad,
    output logic [CW-1:0]     count_pad
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1
    localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    // Count value seen during the final RUN cycle
    localparam logic [CW-1:0]     LAST_CNT = CW'(NUM_PATTERNS - 1);

    bist_state_e       r_state;
    logic [LFSR_W-1:0] r_lfsr;
    logic [CW-1:0]     r_count;
    logic              r_busy;
    logic              r_done;

    logic              w_run;
    logic              w_abort;
    logic              w_misr_clr;
    logic [MISR_W-1:0] w_sig;

    assign w_run = (r_state == RUN);

`ifdef B1_BIST_ABORT_EN
    // Abort only matters while a test is in flight
    assign w_abort = abort_pad & ((r_state == SEED) | (r_state == RUN));
`else
    assign w_abort = 1'b0;
`endif

    // Sequencer: state, pattern generator, pattern counter and registered status flags
    always_ff @(posedge clk_pad or posedge rst_pad) begin
        if (rst_pad) begin
            r_state <= IDLE;
            r_lfsr  <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_pad) begin
                        r_state <= SEED;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                SEED: begin
                    if (w_abort) begin
                        r_state <= IDLE;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= RUN;
                        r_lfsr  <= SEED_EFF;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                RUN: begin
                    if (w_abort) begin
                        // Abort wins even over the final pattern's RUN->DONE step
                        r_state <= IDLE;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end else begin
                        r_lfsr  <= lfsr_next(r_lfsr);
                        r_count <= r_count + CW'(1);
                        if (r_count == LAST_CNT) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    // Signature and count are held until a rerun is requested
                    if (start_pad) begin
                        r_state <= SEED;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_lfsr  <= '0;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Signature starts from zero on every seed and after an abort
    assign w_misr_clr = (r_state == SEED) | w_abort;

    b1_misr u_misr (
        .clk    (clk_pad),
        .rst    (rst_pad),
        .i_clr  (w_misr_clr),
        .i_en   (w_run),
        .i_data ({g_pad, f_pad, e_pad}),
        .o_sig  (w_sig)
    );

    // The core is combinational: its response to this pattern is absorbed at the next edge
    assign {d_pad, b_pad, a_pad} = w_run ? r_lfsr[2:0] : 3'b000;

    assign busy_pad  = r_busy;
    assign done_pad  = r_done;
    assign pass_pad  = r_done & (w_sig == GOLDEN_SIG);
    assign sig_pad   = w_sig;
    assign count_pad = r_count;

endmodule

// File: tb/tb_b1_bist_ctrl.sv
// tb_b1_bist_ctrl: directed bench for b1_bist_ctrl with a small behavioural CUT
// standing in for b1_comb: e = a|b, f = a&b, g = b&~d.
module tb_b1_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference signature of an n-pattern run, optionally with e inverted
    function automatic logic [15:0] model_sig(input int n, input logic [7:0] seed, input logic inv_e);
        logic [7:0]  q;
        logic [15:0] m;
        logic        a, b, d, e, f, g;
        q = (seed == 8'h00) ? 8'h01 : seed;
        m = 16'h0000;
        for (int i = 0; i < n; i++) begin
            a = q[0];
            b = q[1];
            d = q[2];
            e = (a | b) ^ inv_e;
            f = a & b;
            g = b & ~d;
            m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {13'd0, g, f, e};
            q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
        return m;
    endfunction

    localparam logic [15:0] GOLD64 = model_sig(64, 8'hA5, 1'b0);

    // ---------------- main instance: 64 patterns, golden = model ----------------
    logic st_m = 1'b0, inv_m = 1'b0;
    logic a_m, b_m, d_m, e_m, f_m, g_m, busy_m, done_m, pass_m;
    logic [15:0] sig_m;
    logic [6:0]  cnt_m;
`ifdef B1_BIST_ABORT_EN
    logic abort_m = 1'b0;
`endif
    assign e_m = (a_m | b_m) ^ inv_m;
    assign f_m = a_m & b_m;
    assign g_m = b_m & ~d_m;

    b1_bist_ctrl #(.NUM_PATTERNS(64), .LFSR_SEED(8'hA5), .GOLDEN_SIG(GOLD64)) u_main (
        .clk_pad(clk), .rst_pad(rst), .start_pad(st_m),
`ifdef B1_BIST_ABORT_EN
        .abort_pad(abort_m),
`endif
        .a_pad(a_m), .b_pad(b_m), .d_pad(d_m), .e_pad(e_m), .f_pad(f_m), .g_pad(g_m),
        .busy_pad(busy_m), .done_pad(done_m), .pass_pad(pass_m), .sig_pad(sig_m), .count_pad(cnt_m)
    );

    // ---------------- single-pattern instance ----------------
    logic st_1 = 1'b0;
    logic a_1, b_1, d_1, e_1, f_1, g_1, busy_1, done_1, pass_1;
    logic [15:0] sig_1;
    logic [0:0]  cnt_1;
    assign e_1 = a_1 | b_1;
    assign f_1 = a_1 & b_1;
    assign g_1 = b_1 & ~d_1;

    b1_bist_ctrl #(.NUM_PATTERNS(1), .LFSR_SEED(8'hA5), .GOLDEN_SIG(16'h0000)) u_one (
        .clk_pad(clk), .rst_pad(rst), .start_pad(st_1),
`ifdef B1_BIST_ABORT_EN
        .abort_pad(1'b0),
`endif
        .a_pad(a_1), .b_pad(b_1), .d_pad(d_1), .e_pad(e_1), .f_pad(f_1), .g_pad(g_1),
        .busy_pad(busy_1), .done_pad(done_1), .pass_pad(pass_1), .sig_pad(sig_1), .count_pad(cnt_1)
    );

    // ---------------- zero-seed instance ----------------
    logic st_0 = 1'b0;
    logic a_0, b_0, d_0, e_0, f_0, g_0, busy_0, done_0, pass_0;
    logic [15:0] sig_0;
    logic [2:0]  cnt_0;
    assign e_0 = a_0 | b_0;
    assign f_0 = a_0 & b_0;
    assign g_0 = b_0 & ~d_0;

    b1_bist_ctrl #(.NUM_PATTERNS(4), .LFSR_SEED(8'h00), .GOLDEN_SIG(16'h0000)) u_zero (
        .clk_pad(clk), .rst_pad(rst), .start_pad(st_0),
`ifdef B1_BIST_ABORT_EN
        .abort_pad(1'b0),
`endif
        .a_pad(a_0), .b_pad(b_0), .d_pad(d_0), .e_pad(e_0), .f_pad(f_0), .g_pad(g_0),
        .busy_pad(busy_0), .done_pad(done_0), .pass_pad(pass_0), .sig_pad(sig_0), .count_pad(cnt_0)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start the main instance at the current cycle (cycle 0) and run it to DONE
    task automatic main_run(input logic [15:0] exp_sig, input logic exp_pass,
                            input logic hold_start, input logic detail);
        int cyc;
        st_m = 1'b1;
        tick();
        cyc = 1;
        if (!hold_start) st_m = 1'b0;
        check_eq("busy_seed", {31'd0, busy_m}, 32'd1);
        check_eq("stim_seed", {29'd0, d_m, b_m, a_m}, 32'd0);
        while (done_m !== 1'b1 && cyc < 300) begin
            tick();
            cyc++;
            if (cyc == 60) st_m = 1'b0;
            if (detail) begin
                if (cyc == 2) begin
                    check_eq("stim_c2", {29'd0, d_m, b_m, a_m}, 32'h5);
                    check_eq("sig_c2", {16'd0, sig_m}, 32'h0000);
                    check_eq("cnt_c2", {25'd0, cnt_m}, 32'd0);
                end
                if (cyc == 3) begin
                    check_eq("stim_c3", {29'd0, d_m, b_m, a_m}, 32'h2);
                    check_eq("sig_c3", {16'd0, sig_m}, 32'h0001);
                    check_eq("cnt_c3", {25'd0, cnt_m}, 32'd1);
                end
                if (cyc == 4) begin
                    check_eq("sig_c4", {16'd0, sig_m}, 32'h0007);
                end
            end
        end
        check_eq("done_cycle", cyc, 32'd66);
        check_eq("done_count", {25'd0, cnt_m}, 32'd64);
        check_eq("done_sig", {16'd0, sig_m}, {16'd0, exp_sig});
        check_eq("done_pass", {31'd0, pass_m}, {31'd0, exp_pass});
        check_eq("done_busy", {31'd0, busy_m}, 32'd0);
    endtask

    initial begin
        logic [15:0] bad_sig;
        bad_sig = model_sig(64, 8'hA5, 1'b1);

        // Reset asserted from time 0
        #2;
        check_eq("rst_busy", {31'd0, busy_m}, 32'd0);
        check_eq("rst_done", {31'd0, done_m}, 32'd0);
        check_eq("rst_pass", {31'd0, pass_m}, 32'd0);
        check_eq("rst_sig", {16'd0, sig_m}, 32'd0);
        check_eq("rst_cnt", {25'd0, cnt_m}, 32'd0);
        #20 rst = 1'b0;
        tick();
        check_eq("idle_busy", {31'd0, busy_m}, 32'd0);

        // Nominal run with first-pattern detail, then hold in DONE
        main_run(GOLD64, 1'b1, 1'b0, 1'b1);
        repeat (3) tick();
        check_eq("hold_sig", {16'd0, sig_m}, {16'd0, GOLD64});
        check_eq("hold_done", {31'd0, done_m}, 32'd1);
        check_eq("hold_cnt", {25'd0, cnt_m}, 32'd64);

        // Rerun from DONE with start held through RUN: no restart, same signature
        main_run(GOLD64, 1'b1, 1'b1, 1'b0);

        // Faulty core (e inverted): signature differs, pass low, DONE ignores responses
        inv_m = 1'b1;
        main_run(bad_sig, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check_eq("fault_hold_sig", {16'd0, sig_m}, {16'd0, bad_sig});
        inv_m = 1'b0;

        // Asynchronous reset mid-run
        st_m = 1'b1;
        tick();
        st_m = 1'b0;
        repeat (8) tick();
        check_eq("pre_rst_busy", {31'd0, busy_m}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("arst_busy", {31'd0, busy_m}, 32'd0);
        check_eq("arst_stim", {29'd0, d_m, b_m, a_m}, 32'd0);
        check_eq("arst_sig", {16'd0, sig_m}, 32'd0);
        check_eq("arst_cnt", {25'd0, cnt_m}, 32'd0);
        #2 rst = 1'b0;
        tick();
        check_eq("post_rst_busy", {31'd0, busy_m}, 32'd0);
        check_eq("post_rst_done", {31'd0, done_m}, 32'd0);

        // NUM_PATTERNS=1: one pattern, DONE at cycle 3
        st_1 = 1'b1;
        tick();
        st_1 = 1'b0;
        tick();
        check_eq("one_stim_c2", {29'd0, d_1, b_1, a_1}, 32'h5);
        check_eq("one_done_c2", {31'd0, done_1}, 32'd0);
        tick();
        check_eq("one_done_c3", {31'd0, done_1}, 32'd1);
        check_eq("one_cnt", {31'd0, cnt_1}, 32'd1);
        check_eq("one_sig", {16'd0, sig_1}, 32'h0001);
        check_eq("one_pass", {31'd0, pass_1}, 32'd0);

        // LFSR_SEED=0 is replaced by 1
        st_0 = 1'b1;
        tick();
        st_0 = 1'b0;
        tick();
        check_eq("zero_stim_c2", {29'd0, d_0, b_0, a_0}, 32'h1);
        tick();
        check_eq("zero_stim_c3", {29'd0, d_0, b_0, a_0}, 32'h2);
        check_eq("zero_sig_c3", {16'd0, sig_0}, 32'h0001);

`ifdef B1_BIST_ABORT_EN
        begin
            logic seen_done;
            st_m = 1'b1;
            tick();
            st_m = 1'b0;
            repeat (9) tick();
            abort_m = 1'b1;
            tick();
            abort_m = 1'b0;
            check_eq("abort_busy", {31'd0, busy_m}, 32'd0);
            check_eq("abort_sig", {16'd0, sig_m}, 32'd0);
            check_eq("abort_cnt", {25'd0, cnt_m}, 32'd0);
            seen_done = 1'b0;
            for (int k = 0; k < 80; k++) begin
                tick();
                if (done_m === 1'b1) seen_done = 1'b1;
            end
            check_eq("abort_no_done", {31'd0, seen_done}, 32'd0);
            main_run(GOLD64, 1'b1, 1'b0, 1'b0);
            abort_m = 1'b1;
            tick();
            abort_m = 1'b0;
            check_eq("abort_in_done", {31'd0, done_m}, 32'd1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
